vga_pixel_fetch: RTL and testbench

- Sits between the data memory's VGA read port and the VGA controller.
- Prefetches packed framebuffer words from data memory ahead of the raster and buffers them in a small FIFO.
- Unpacks each word into four RGB332 pixels and delivers them as 8-bit R/G/B, one pixel per request from the VGA timing logic.
- Decouples memory read latency from pixel timing.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_pixel_fetch_if.sv | 21 ++
 rtl/vga_word_fifo.sv | 65 ++++++
 rtl/vga_pixel_fetch.sv | 156 +++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: framebuffer location, default raster size,
// the packed RGB332 pixel format and its expansion to 8-bit channels,
// and the state encoding of the framebuffer prefetch engine.
package vga_pkg;

  localparam int          H_RES_DEF   = 640;
  localparam int          V_RES_DEF   = 480;
  localparam logic [31:0] VGA_FB_BASE = 32'h0000_2000;

  // One framebuffer byte: 3 bits red, 3 bits green, 2 bits blue (MSB first).
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Prefetch engine: idle until the first frame_start, then alternates
  // between looking for room (RUN) and waiting for read data (WAIT).
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;

  // Bit replication so full-scale codes map to 255 and zero maps to 0.
  function automatic rgb888_t expand_rgb332(input rgb332_t px);
    rgb888_t o;
    o.r = {px.r, px.r, px.r[2:1]};
    o.g = {px.g, px.g, px.g[2:1]};
    o.b = {px.b, px.b, px.b, px.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Read port between the pixel fetch block (master) and the data memory's
// VGA port (slave). Read data is valid the cycle after mem_rd.
interface vga_pixel_fetch_if;

  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );

endinterface

// File: rtl/vga_word_fifo.sv
// Small synchronous word FIFO with flush. Head word is visible on dout
// without a read strobe; pop advances it. Push and pop in the same cycle
// both take effect and leave the count unchanged.
module vga_word_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign dout    = store[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      store[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetch and pixel unpack for the VGA controller.
// Reads packed words (four RGB332 pixels, byte 0 leftmost) ahead of the
// raster with a single outstanding read, buffers them, and hands out one
// expanded pixel per pix_req with one cycle of latency.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = VGA_FB_BASE,
  parameter int          H_RES      = H_RES_DEF,
  parameter int          V_RES      = V_RES_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_req,
  vga_pixel_fetch_if.master mem,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              pix_valid,
  output logic              underflow
);

  localparam int WORDS = H_RES * V_RES / 4;
  localparam int WC_W  = $clog2(WORDS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic             issue;
  logic             push;
  logic [WC_W-1:0]  word_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_dout;
  logic             have_word;
  logic             room;
  logic             accept;
  logic             pop;
  logic [1:0]       sub_idx;
  logic [7:0]       pix_byte_p0;
  rgb888_t          pix_p0;

  // In-flight read == WAIT state, so count + in-flight < depth reduces to
  // a plain count check when a new read is considered in RUN.
  assign room      = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign have_word = (fifo_count != '0);

  // Returning data is dropped when a frame restart coincides with it.
  assign push      = (state == FETCH_WAIT) && !frame_start;
  assign accept    = pix_req && !frame_start;
  assign pop       = accept && have_word && (sub_idx == 2'd3);

  assign mem.mem_rd   = issue;
  assign mem.mem_addr = BASE_ADDR + (32'(word_cnt) << 2);

  // Fetch state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch next-state and read issue; frame_start overrides everything.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (frame_start) begin
      state_nxt = FETCH_RUN;
    end else begin
      case (state)
        FETCH_IDLE: state_nxt = FETCH_IDLE;
        FETCH_RUN: begin
          if (room && (word_cnt < WC_W'(WORDS))) begin
            issue     = 1'b1;
            state_nxt = FETCH_WAIT;
          end
        end
        FETCH_WAIT: state_nxt = FETCH_RUN;
        default:    state_nxt = FETCH_IDLE;
      endcase
    end
  end

  // Word counter: advances on each issued read, rewinds on frame restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if (frame_start) begin
      word_cnt <= '0;
    end else if (issue) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  vga_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (frame_start),
    .push  (push),
    .pop   (pop),
    .din   (mem.mem_data),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Stage p0: select the current byte of the head word and expand it;
  // an empty FIFO yields black.
  always_comb begin
    pix_byte_p0 = fifo_dout[7:0];
    case (sub_idx)
      2'd1:    pix_byte_p0 = fifo_dout[15:8];
      2'd2:    pix_byte_p0 = fifo_dout[23:16];
      2'd3:    pix_byte_p0 = fifo_dout[31:24];
      default: pix_byte_p0 = fifo_dout[7:0];
    endcase
    pix_p0 = '0;
    if (have_word) begin
      pix_p0 = expand_rgb332(rgb332_t'(pix_byte_p0));
    end
  end

  // Stage p1: registered pixel output, sub-pixel index and underflow flag.
  // The index advances even on underflow to keep the raster aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
      sub_idx   <= '0;
    end else if (frame_start) begin
      pix_valid <= 1'b0;
      underflow <= 1'b0;
      sub_idx   <= '0;
    end else begin
      pix_valid <= accept;
      if (accept) begin
        sub_idx <= sub_idx + 1'b1;
        r       <= pix_p0.r;
        g       <= pix_p0.g;
        b       <= pix_p0.b;
        if (!have_word) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a one-cycle-latency memory model.
module tb_vga_pixel_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pix_req;
  logic [7:0] r, g, b;
  logic       pix_valid;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  int rd_total = 0;
  int rd_base  = 0;
  int addr_bad = 0;

  vga_pixel_fetch_if bus ();

  vga_pixel_fetch #(
    .H_RES (640),
    .V_RES (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .mem         (bus),
    .r           (r),
    .g           (g),
    .b           (b),
    .pix_valid   (pix_valid),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fb_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr - 32'h0000_2000) >> 2;
    if (idx == 32'd0) return 32'hE01C_03FF;
    return {idx[7:0], idx[7:0], idx[7:0], idx[7:0]};
  endfunction

  function automatic logic [23:0] ref_px(input logic [7:0] v);
    logic [7:0] rr, gg, bb;
    rr = {v[7:5], v[7:5], v[7:6]};
    gg = {v[4:2], v[4:2], v[4:3]};
    bb = {v[1:0], v[1:0], v[1:0], v[1:0]};
    return {rr, gg, bb};
  endfunction

  // Memory: data for the address read this cycle appears next cycle.
  always @(posedge clk) begin
    bus.mem_data <= bus.mem_rd ? fb_word(bus.mem_addr) : 32'hDEAD_BEEF;
  end

  // Read monitor: counts reads and checks address contiguity since rd_base.
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      if (bus.mem_addr !== 32'h0000_2000 + 32'(4 * (rd_total - rd_base))) addr_bad++;
      rd_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] px_tab [5];
  int          ab0;
  int          rdsnap;
  int          nvalid;
  int          nbad;
  logic [31:0] w;
  logic [7:0]  by;

  initial begin
    px_tab[0] = 24'hFFFFFF;
    px_tab[1] = 24'h0000FF;
    px_tab[2] = 24'h00FF00;
    px_tab[3] = 24'hFF0000;
    px_tab[4] = 24'h000055;

    reset = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
    #2;
    chk("rst_addr", bus.mem_addr, 32'h0000_2000);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_pv", pix_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_cnt", u_dut.u_fifo.count, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rel_rd0", bus.mem_rd, 0);
    tick(); tick();
    chk("rel_rd1", bus.mem_rd, 0);

    // Prefetch after frame_start fills the FIFO with exactly 8 reads.
    frame_start = 1'b1; rd_base = rd_total; ab0 = addr_bad;
    #1;
    chk("fs_cycle_rd", bus.mem_rd, 0);
    tick();
    frame_start = 1'b0;
    #1;
    chk("first_rd", bus.mem_rd, 1);
    chk("first_addr", bus.mem_addr, 32'h0000_2000);
    tick();
    chk("second_addr", bus.mem_addr, 32'h0000_2004);
    repeat (30) tick();
    chk("fill_reads", rd_total - rd_base, 8);
    chk("fill_count", u_dut.u_fifo.count, 8);
    chk("fill_addr", addr_bad - ab0, 0);

    // Unpack word 0 byte by byte, then the head moves to word 1.
    for (int i = 0; i < 5; i++) begin
      pix_req = 1'b1;
      tick();
      chk($sformatf("px%0d", i), {r, g, b}, px_tab[i]);
      chk($sformatf("px%0d_pv", i), pix_valid, 1);
    end
    pix_req = 1'b0;
    tick();
    chk("idle_pv", pix_valid, 0);
    chk("idle_hold", {r, g, b}, 24'h000055);

    // Whole 2-line frame with continuous requests, then one beyond the end.
    frame_start = 1'b1; rd_base = rd_total; ab0 = addr_bad;
    tick();
    frame_start = 1'b0;
    repeat (20) tick();
    nvalid = 0; nbad = 0;
    for (int n = 0; n < 1280; n++) begin
      pix_req = 1'b1;
      tick();
      if (pix_valid === 1'b1) nvalid++;
      w  = fb_word(32'h0000_2000 + 32'(4 * (n / 4)));
      by = w[8 * (n % 4) +: 8];
      if ({r, g, b} !== ref_px(by)) nbad++;
      if (n == 639) begin
        chk("line_valid", nvalid, 640);
        chk("line_uf", underflow, 0);
        chk("line_px", nbad, 0);
      end
    end
    chk("frame_valid", nvalid, 1280);
    chk("frame_uf", underflow, 0);
    chk("frame_px", nbad, 0);
    tick();
    chk("past_end_rgb", {r, g, b}, 0);
    chk("past_end_pv", pix_valid, 1);
    chk("past_end_uf", underflow, 1);
    chk("frame_reads", rd_total - rd_base, 320);
    chk("frame_addr", addr_bad - ab0, 0);

    // Flush then request immediately: underflow, cleared by next frame_start.
    frame_start = 1'b1; rd_base = rd_total;
    tick();
    chk("fs_req_pv", pix_valid, 0);
    chk("fs_uf_clr", underflow, 0);
    frame_start = 1'b0;
    tick();
    chk("uf_rgb", {r, g, b}, 0);
    chk("uf_pv", pix_valid, 1);
    chk("uf_set", underflow, 1);
    pix_req = 1'b0;
    repeat (3) tick();
    chk("uf_sticky", underflow, 1);
    frame_start = 1'b1; rd_base = rd_total;
    tick();
    chk("uf_clear", underflow, 0);

    // frame_start while a read is returning: data dropped, fetch restarts.
    frame_start = 1'b0;
    #1;
    chk("rd_after_fs", bus.mem_rd, 1);
    tick();
    frame_start = 1'b1; pix_req = 1'b1; rd_base = rd_total;
    tick();
    chk("drop_pv", pix_valid, 0);
    chk("drop_cnt", u_dut.u_fifo.count, 0);
    frame_start = 1'b0; pix_req = 1'b0;
    #1;
    chk("drop_rd", bus.mem_rd, 1);
    chk("drop_addr", bus.mem_addr, 32'h0000_2000);
    repeat (8) tick();
    pix_req = 1'b1;
    tick();
    chk("restart_px0", {r, g, b}, 24'hFFFFFF);
    tick();
    chk("restart_px1", {r, g, b}, 24'h0000FF);
    chk("pre_rst_cnt_nz", (u_dut.u_fifo.count != 0), 1);

    // Asynchronous reset mid-line: outputs clear before the next edge.
    #3;
    reset = 1'b0;
    #1;
    chk("arst_rgb", {r, g, b}, 0);
    chk("arst_pv", pix_valid, 0);
    chk("arst_uf", underflow, 0);
    chk("arst_rd", bus.mem_rd, 0);
    chk("arst_addr", bus.mem_addr, 32'h0000_2000);
    chk("arst_cnt", u_dut.u_fifo.count, 0);
    pix_req = 1'b0;
    tick();
    reset = 1'b1; rdsnap = rd_total;
    repeat (6) tick();
    chk("arst_no_fetch", rd_total - rdsnap, 0);
    frame_start = 1'b1; rd_base = rd_total;
    tick();
    frame_start = 1'b0;
    #1;
    chk("arst_resume_rd", bus.mem_rd, 1);
    chk("arst_resume_addr", bus.mem_addr, 32'h0000_2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
